// File: rtl/mac_pipe_if.sv
// Streaming bus for mac_pipe: sample inputs in, result/status out.
interface mac_pipe_if #(
  parameter int LENGTH = 8,
  parameter int ACC_W  = 2*LENGTH+4,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              mode;
  logic              acc_clr;
  logic [LENGTH-1:0] A;
  logic [LENGTH-1:0] B;
  logic [LENGTH-1:0] C;
  logic              out_valid;
  logic [ACC_W-1:0]  DATA;
  logic              ovf;
  logic [CNT_W-1:0]  sample_cnt;

  // Sample source side
  modport master (
    output in_valid, mode, acc_clr, A, B, C,
    input  out_valid, DATA, ovf, sample_cnt
  );

  // MAC unit side
  modport slave (
    input  in_valid, mode, acc_clr, A, B, C,
    output out_valid, DATA, ovf, sample_cnt
  );
endinterface

// File: rtl/mac_pipe.sv
// Three-stage multiply-add / multiply-accumulate unit.
//   S1: register operands and control.
//   S2: form the 2*LENGTH product, delay C/control alongside.
//   S3: add into DATA (MAD) or into the running accumulator (ACC).
// No back-pressure: one sample per clock, fixed two-edge latency to DATA.
module mac_pipe #(
  parameter int LENGTH = 8,
  parameter int ACC_W  = 2*LENGTH+4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  mac_pipe_if.slave bus
);

  localparam int PW     = 2*LENGTH;
  localparam int STAGES = 3;
  localparam bit SX     = (SIGNED != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The MAD path relies on ACC_W holding a full product plus addend.
  generate
    if (ACC_W < 2*LENGTH+1) begin : g_bad_acc_w
      $error("mac_pipe: ACC_W (%0d) must be >= 2*LENGTH+1 (%0d)", ACC_W, 2*LENGTH+1);
    end
  endgenerate

  typedef struct packed {
    logic              mode;
    logic              clr;
    logic [LENGTH-1:0] a;
    logic [LENGTH-1:0] b;
    logic [LENGTH-1:0] c;
  } s1_t;

  typedef struct packed {
    logic              mode;
    logic              clr;
    logic [PW-1:0]     prod;
    logic [LENGTH-1:0] c;
  } s2_t;

  // vld_pipe[1] = S1, [2] = S2, [3] = out_valid
  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  s2_t              s2;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] data_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  // Valid shift register; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // S1: capture operands and control every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.mode <= bus.mode;
      s1.clr  <= bus.acc_clr;
      s1.a    <= bus.A;
      s1.b    <= bus.B;
      s1.c    <= bus.C;
    end
  end

  // Extend to 2*LENGTH before multiplying: the low 2*LENGTH bits of the
  // product of extended operands equal the signed or unsigned product.
  logic [PW-1:0] ax, bx, prod_s1;
  always_comb begin
    ax      = SX ? {{LENGTH{s1.a[LENGTH-1]}}, s1.a} : {{LENGTH{1'b0}}, s1.a};
    bx      = SX ? {{LENGTH{s1.b[LENGTH-1]}}, s1.b} : {{LENGTH{1'b0}}, s1.b};
    prod_s1 = ax * bx;
  end

  // S2: product register plus delayed C and control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else begin
      s2.mode <= s1.mode;
      s2.clr  <= s1.clr;
      s2.prod <= prod_s1;
      s2.c    <= s1.c;
    end
  end

  // S3 arithmetic: extended operands, accumulate sum with overflow, MAD sum,
  // and the saturating sample counter's next value.
  logic [ACC_W-1:0] p_ext, c_ext, base, sum, mad;
  logic             carry, ov;
  logic [CNT_W-1:0] cnt_nxt;
  always_comb begin
    p_ext = {{(ACC_W-PW){SX & s2.prod[PW-1]}}, s2.prod};
    c_ext = {{(ACC_W-LENGTH){SX & s2.c[LENGTH-1]}}, s2.c};
    base  = s2.clr ? '0 : acc;
    {carry, sum} = {1'b0, base} + {1'b0, p_ext};
    if (SX) ov = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    else    ov = carry;
    mad = p_ext + c_ext;
    if (s2.clr)              cnt_nxt = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_nxt = cnt_q;
    else                     cnt_nxt = cnt_q + CNT_W'(1);
  end

  // S3: result register, accumulator, sticky overflow and sample count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (vld_pipe[2]) begin
      if (s2.mode) begin
        acc    <= sum;
        data_q <= sum;
        ovf_q  <= (ovf_q & ~s2.clr) | ov;
        cnt_q  <= cnt_nxt;
      end else begin
        data_q <= mad;
        if (s2.clr) begin
          acc   <= '0;
          ovf_q <= 1'b0;
          cnt_q <= '0;
        end
      end
    end else if (s2.clr) begin
      // bubble clear: state reset, DATA held
      acc   <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end
  end

  assign bus.out_valid  = vld_pipe[STAGES];
  assign bus.DATA       = data_q;
  assign bus.ovf        = ovf_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: an unsigned and a signed instance share clock
// and reset; expected results are queued at drive time and popped on out_valid.
module tb_mac_pipe;
  localparam int L  = 8;
  localparam int AW = 20;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_pipe_if #(.LENGTH(L), .ACC_W(AW), .CNT_W(CW)) bu ();
  mac_pipe_if #(.LENGTH(L), .ACC_W(AW), .CNT_W(CW)) bs ();

  mac_pipe #(.LENGTH(L), .ACC_W(AW), .SIGNED(0), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bu.slave));
  mac_pipe #(.LENGTH(L), .ACC_W(AW), .SIGNED(1), .CNT_W(CW)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));

  typedef struct {
    logic [31:0] d;
    logic        o;
    logic [31:0] c;
  } exp_t;

  exp_t qu[$];
  exp_t qs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic put_u(input logic v, input logic m, input logic cl,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [31:0] d, input logic o, input logic [31:0] cn);
    exp_t e;
    bu.in_valid = v; bu.mode = m; bu.acc_clr = cl;
    bu.A = a; bu.B = b; bu.C = c;
    if (v) begin
      e.d = d; e.o = o; e.c = cn;
      qu.push_back(e);
    end
  endtask

  task automatic put_s(input logic v, input logic m, input logic cl,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [31:0] d, input logic o, input logic [31:0] cn);
    exp_t e;
    bs.in_valid = v; bs.mode = m; bs.acc_clr = cl;
    bs.A = a; bs.B = b; bs.C = c;
    if (v) begin
      e.d = d; e.o = o; e.c = cn;
      qs.push_back(e);
    end
  endtask

  task automatic idle_u(); put_u(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle_s(); put_s(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Advance to the next falling edge and score any result that emerged.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bu.out_valid) begin
      if (qu.size() == 0) chk("u_spurious_valid", {31'd0, bu.out_valid}, 32'd0);
      else begin
        e = qu.pop_front();
        chk("u_data", bu.DATA, e.d);
        chk("u_ovf", {31'd0, bu.ovf}, {31'd0, e.o});
        chk("u_cnt", bu.sample_cnt, e.c);
      end
    end
    if (bs.out_valid) begin
      if (qs.size() == 0) chk("s_spurious_valid", {31'd0, bs.out_valid}, 32'd0);
      else begin
        e = qs.pop_front();
        chk("s_data", bs.DATA, e.d);
        chk("s_ovf", {31'd0, bs.ovf}, {31'd0, e.o});
        chk("s_cnt", bs.sample_cnt, e.c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_u();
    idle_s();
    // reset state, before any clock edge
    #2;
    chk("rst_u_valid", {31'd0, bu.out_valid}, 32'd0);
    chk("rst_u_data", bu.DATA, 32'd0);
    chk("rst_u_ovf", {31'd0, bu.ovf}, 32'd0);
    chk("rst_u_cnt", bu.sample_cnt, 32'd0);
    chk("rst_s_valid", {31'd0, bs.out_valid}, 32'd0);
    chk("rst_s_data", bs.DATA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single MAD sample, latency check
    put_u(1, 0, 0, 200, 100, 55, 20055, 0, 0);
    tick();
    idle_u();
    chk("lat_edge_n", {31'd0, bu.out_valid}, 32'd0);
    tick();
    chk("lat_edge_n1", {31'd0, bu.out_valid}, 32'd0);
    tick();
    chk("lat_edge_n2", {31'd0, bu.out_valid}, 32'd1);
    tick();
    chk("lat_after", {31'd0, bu.out_valid}, 32'd0);

    // back-to-back MAD stream
    put_u(1, 0, 0, 1, 2, 3, 5, 0, 0);           tick();
    put_u(1, 0, 0, 4, 5, 6, 26, 0, 0);          tick();
    put_u(1, 0, 0, 255, 255, 255, 65280, 0, 0); tick();
    idle_u();
    chk("strm_v0", {31'd0, bu.out_valid}, 32'd1);
    tick(); chk("strm_v1", {31'd0, bu.out_valid}, 32'd1);
    tick(); chk("strm_v2", {31'd0, bu.out_valid}, 32'd1);
    tick(); chk("strm_end_valid", {31'd0, bu.out_valid}, 32'd0);
    chk("strm_hold", bu.DATA, 32'd65280);

    // ACC with clear on first sample, C ignored
    put_u(1, 1, 1, 10, 10, 99, 100, 0, 1); tick();
    put_u(1, 1, 0, 20, 5, 77, 200, 0, 2);  tick();
    put_u(1, 1, 0, 3, 3, 0, 209, 0, 3);    tick();
    idle_u();
    repeat (3) tick();

    // ACC overflow: 17 x 65025 wraps past 2^20 on the 17th sample
    for (int k = 1; k <= 17; k++) begin
      put_u(1, 1, (k == 1), 255, 255, 0, (k * 65025) % (1 << 20), (k == 17), k);
      tick();
    end
    idle_u();
    repeat (3) tick();
    chk("ovf_sticky", {31'd0, bu.ovf}, 32'd1);
    // bubble clear
    put_u(0, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    idle_u();
    repeat (3) tick();
    chk("bub_ovf", {31'd0, bu.ovf}, 32'd0);
    chk("bub_cnt", bu.sample_cnt, 32'd0);
    chk("bub_valid", {31'd0, bu.out_valid}, 32'd0);
    chk("bub_hold", bu.DATA, 32'd56849);

    // sample_cnt saturation
    for (int k = 1; k <= 260; k++) begin
      put_u(1, 1, (k == 1), 0, 5, 0, 0, 0, (k > 255) ? 255 : k);
      tick();
    end
    idle_u();
    repeat (3) tick();

    // signed instance: MAD with negatives, ACC of -128*-128
    put_s(1, 0, 0, 8'hFD, 8'h07, 8'hFF, 32'hFFFEA, 0, 0); tick();
    put_s(1, 1, 1, 8'h80, 8'h80, 8'h00, 16384, 0, 1);      tick();
    idle_s();
    repeat (3) tick();

    // reset with two samples in flight
    put_u(1, 0, 0, 1, 2, 3, 5, 0, 255); tick();
    idle_u();
    repeat (3) tick();
    put_u(1, 1, 0, 9, 9, 0, 0, 0, 0); tick();   // discarded by reset
    put_u(1, 1, 0, 9, 9, 0, 0, 0, 0); tick();   // discarded by reset
    void'(qu.pop_back());
    void'(qu.pop_back());
    idle_u();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bu.out_valid}, 32'd0);
    chk("mid_rst_data", bu.DATA, 32'd0);
    chk("mid_rst_cnt", bu.sample_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", {31'd0, bu.out_valid}, 32'd0);
    end

    chk("u_pending", qu.size(), 32'd0);
    chk("s_pending", qs.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, pipelined multiply-add / multiply-accumulate unit.
- MAD mode computes DATA = A*B + C. ACC mode keeps a running sum of A*B.
- Valid-qualified streaming datapath for filter and correlator chains. Accepts one sample per clock, no back-pressure.
- Reports overflow (sticky) and the number of samples accumulated.

Parameters:
- LENGTH, 8: width of operands A, B, C.
- ACC_W, 2*LENGTH+4: width of DATA and the accumulator. Must be >= 2*LENGTH+1; elaboration error otherwise.
- SIGNED, 0: 0 = unsigned operands/arithmetic, 1 = two's-complement.
- CNT_W, 8: width of sample_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B/C/mode carry a sample this cycle
- mode  input  1  0 = MAD, 1 = ACC; sampled with in_valid
- acc_clr  input  1  clear accumulator, ovf and sample_cnt; travels with the pipeline
- A  input  LENGTH  multiplicand
- B  input  LENGTH  multiplier
- C  input  LENGTH  addend (MAD only)
- out_valid  output  1  DATA carries a new result
- DATA  output  ACC_W  result
- ovf  output  1  sticky accumulator overflow
- sample_cnt  output  CNT_W  ACC samples since last clear, saturating

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- While rst_n=0 all pipeline registers, the accumulator, DATA, out_valid, ovf and sample_cnt are 0, immediately, without waiting for a clock edge.
- Samples in flight when reset asserts are discarded. Nothing emerges after reset is released.
- Pipeline stages:
  - S1 registers A, B, C, mode, in_valid, acc_clr.
  - S2 registers the 2*LENGTH product and a delayed copy of C, mode, valid and clr.
  - S3 updates the accumulator and registers DATA and out_valid.
- Latency: sample taken at edge N gives out_valid=1 with DATA valid after edge N+2. Throughput is 1 sample/clock. Valid samples on consecutive edges give out_valid high on consecutive cycles.
- Operand extension to ACC_W: zero-extend if SIGNED=0, sign-extend if SIGNED=1. The product is computed signed or unsigned accordingly.
- MAD sample at S3: DATA = ext(A*B) + ext(C). The accumulator, ovf and sample_cnt are unchanged, except when acc_clr is set, in which case they are cleared. Cannot overflow given the ACC_W rule.
- ACC sample at S3:
  - sum = (acc_clr ? 0 : acc) + ext(A*B), modulo 2^ACC_W. acc <= sum and DATA <= sum. C is ignored.
  - sample_cnt <= (acc_clr ? 1 : sample_cnt+1), saturating at 2^CNT_W-1.
  - Overflow is a carry out of ACC_W bits (unsigned) or two's-complement overflow (signed). On overflow, ovf <= 1 and the sum wraps.
  - ovf is cleared only by acc_clr (in the same S3 cycle, the new sample's overflow is still recorded) or by reset.
- acc_clr with in_valid=0 is a bubble clear: at S3, acc, ovf and sample_cnt go to 0. out_valid=0 and DATA is unchanged.
- out_valid is 0 on bubbles. DATA holds its last value when out_valid=0.
- A mode change between consecutive samples takes effect per sample. There is no flush or stall.

Test Plan:
- MAD, LENGTH=8, ACC_W=20, SIGNED=0: A=200, B=100, C=55, one valid cycle at edge N -> out_valid=1 only after edge N+2, DATA=20055. ovf=0, sample_cnt=0.
- Streaming MAD on back-to-back edges: (1,2,3), (4,5,6), (255,255,255) -> three consecutive out_valid cycles with DATA=5, 26, 65280. Then out_valid=0 and DATA holds 65280.
- ACC: (10,10,C=99) with acc_clr, then (20,5), then (3,3) -> DATA=100, 200, 209 (C ignored). sample_cnt=1, 2, 3. ovf=0.
- ACC overflow: A=B=255 with clr on the first sample, 17 samples. 16th output DATA=1040400, ovf=0. 17th output DATA=56849 (1105425 mod 2^20), ovf=1 and stays 1. A bubble acc_clr -> ovf=0, sample_cnt=0.
- Signed, SIGNED=1: A=0xFD (-3), B=7, C=0xFF (-1), MAD -> DATA=0xFFFEA (-22). ACC: -128*-128 with clr -> DATA=16384.
- Reset mid-operation: drop rst_n with 2 samples in flight -> out_valid=0, DATA=0 and sample_cnt=0 asynchronously. After release with in_valid=0, out_valid stays 0.
